// File: rtl/dht11_frame_reader.sv
// DHT11 single-wire frame reader: host start pulse, sensor response, 40 data bits, checksum.
// Line is open-drain; only the pull-low enable (dht_oe) is driven from here.
// Optional build macro DHT_GLITCH_FILTER_EN: 4-sample glitch filter after the synchronizer.
module dht11_frame_reader #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W    = $clog2(START_LOW_US + TIMEOUT_US + BIT_THRESH_US + 2);

  typedef enum logic [2:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] us_cnt;
  logic [39:0]      shreg;
  logic [5:0]       bit_cnt;
  logic             s1, s2, lvl, lvl_q;

  logic             us_tick_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic             timeout_c, fall_c, rise_c, bit_val_c;
  logic [7:0]       sum_c;

  // Two-flop synchronizer; idle line is pulled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= dht_in;
      s2 <= s1;
    end
  end

`ifdef DHT_GLITCH_FILTER_EN
  logic [1:0] flt_cnt;

  // Accept a new level only after four consecutive matching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl     <= 1'b1;
      flt_cnt <= 2'd0;
    end else if (s2 == lvl) begin
      flt_cnt <= 2'd0;
    end else if (flt_cnt == 2'd3) begin
      lvl     <= s2;
      flt_cnt <= 2'd0;
    end else begin
      flt_cnt <= flt_cnt + 2'd1;
    end
  end
`else
  assign lvl = s2;
`endif

  // Previous line level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b1;
    else     lvl_q <= lvl;
  end

  // Free-running microsecond prescaler.
  always_ff @(posedge clk) begin
    if (rst || us_tick_c) pre <= '0;
    else                  pre <= pre + PRE_W'(1);
  end

  // Elapsed-us view that includes the tick of the current cycle, so a window of
  // N whole microseconds always yields exactly N regardless of prescaler phase.
  always_comb begin
    us_tick_c  = (pre == PRE_W'(TICK_DIV - 1));
    cnt_next_c = us_cnt + CNT_W'(us_tick_c);
    timeout_c  = (cnt_next_c >= CNT_W'(TIMEOUT_US));
    bit_val_c  = (cnt_next_c >= CNT_W'(BIT_THRESH_US));
    fall_c     = lvl_q & ~lvl;
    rise_c     = ~lvl_q & lvl;
    sum_c      = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      us_cnt   <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      dht_oe   <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      hum_int  <= 8'h00;
      hum_dec  <= 8'h00;
      temp_int <= 8'h00;
      temp_dec <= 8'h00;
    end else begin
      valid  <= 1'b0;
      err    <= 1'b0;
      us_cnt <= cnt_next_c;
      case (state)
        IDLE: begin
          us_cnt <= '0;
          if (busy) begin
            busy <= 1'b0;          // strobe cycle just ended
          end else if (start) begin
            busy    <= 1'b1;
            dht_oe  <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= START_LOW;
          end
        end
        START_LOW: begin
          if (cnt_next_c >= CNT_W'(START_LOW_US)) begin
            dht_oe <= 1'b0;
            us_cnt <= '0;
            state  <= RELEASE;
          end
        end
        RELEASE, RESP_LOW, RESP_HIGH: begin
          if (timeout_c) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            state    <= IDLE;
          end else if (state == RELEASE && fall_c) begin
            us_cnt <= '0;
            state  <= RESP_LOW;
          end else if (state == RESP_LOW && rise_c) begin
            us_cnt <= '0;
            state  <= RESP_HIGH;
          end else if (state == RESP_HIGH && fall_c) begin
            us_cnt <= '0;
            state  <= BIT_LOW;
          end
        end
        BIT_LOW: begin
          if (timeout_c) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            state    <= IDLE;
          end else if (rise_c) begin
            us_cnt <= '0;
            state  <= BIT_HIGH;
          end
        end
        BIT_HIGH: begin
          if (timeout_c) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            state    <= IDLE;
          end else if (fall_c) begin
            shreg   <= {shreg[38:0], bit_val_c};
            bit_cnt <= bit_cnt + 6'd1;
            us_cnt  <= '0;
            state   <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
          end
        end
        CHECK: begin
          if (sum_c == shreg[7:0]) begin
            valid    <= 1'b1;
            hum_int  <= shreg[39:32];
            hum_dec  <= shreg[31:24];
            temp_int <= shreg[23:16];
            temp_dec <= shreg[15:8];
          end else begin
            err      <= 1'b1;
            err_code <= 2'd3;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Directed bench for dht11_frame_reader with a behavioural DHT11 sensor model.
module tb_dht11_frame_reader;

  localparam int unsigned US       = 2;     // clk cycles per us (2 MHz clock)
  localparam int unsigned START_US = 100;
  localparam int unsigned TO_US    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  logic       dht_in;
  logic       dht_oe, busy, valid, err;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  int checks = 0;
  int passed = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign dht_in = ~(dht_oe | sensor_low);

  always #5 clk = ~clk;

  dht11_frame_reader #(
    .CLK_HZ(2_000_000), .START_LOW_US(START_US), .TIMEOUT_US(TO_US), .BIT_THRESH_US(50)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dht_in(dht_in), .dht_oe(dht_oe), .busy(busy),
    .valid(valid), .err(err), .err_code(err_code), .hum_int(hum_int), .hum_dec(hum_dec),
    .temp_int(temp_int), .temp_dec(temp_dec)
  );

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (err) err_cnt++;
    if (valid && err) both_cnt++;
  end

  task automatic wait_us(input int n);
    repeat (n * US) @(negedge clk);
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Sensor model: waits for host release, answers, sends nbits MSB first, then a final low.
  task automatic sensor_frame(input logic [39:0] d, input int nbits, input int h0,
                              input int h1, input bit glitchy);
    bit seen = 0;
    bit ok = 0;
    int h;
    for (int i = 0; i < (START_US + 20) * US * 2; i++) begin
      @(negedge clk);
      if (dht_oe) seen = 1;
      if (seen && !dht_oe) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      $display("FAIL release_wait: host release seen=%0b, required 1", ok);
      return;
    end
    passed++;
    wait_us(30);
    sensor_low = 1'b1; wait_us(80);
    sensor_low = 1'b0; wait_us(80);
    for (int i = 0; i < nbits; i++) begin
      sensor_low = 1'b1; wait_us(50);
      sensor_low = 1'b0;
      h = d[39 - i] ? h1 : h0;
      if (glitchy) begin
        wait_us(10);
        sensor_low = 1'b1; repeat (2) @(negedge clk);
        sensor_low = 1'b0; wait_us(h - 11);
      end else begin
        wait_us(h);
      end
    end
    sensor_low = 1'b1; wait_us(50);
    sensor_low = 1'b0;
  endtask

  task automatic wait_strobe(input int max_cyc, output bit v, output bit e,
                             output bit busy_at, output bit busy_after);
    v = 0; e = 0; busy_at = 0; busy_after = 1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid || err) begin
        v = valid; e = err; busy_at = busy;
        @(negedge clk);
        busy_after = busy;
        return;
      end
    end
    $display("FAIL strobe_wait: no valid/err within %0d cycles", max_cyc);
  endtask

  task automatic run_frame(input string name, input logic [39:0] d, input int h0, input int h1,
                           input bit glitchy, input bit exp_v, input logic [31:0] exp_data,
                           input logic [1:0] exp_code);
    bit v, e, ba, bb;
    int vc0 = valid_cnt;
    int ec0 = err_cnt;
    pulse_start;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy_accept: busy=%b required 1", name, busy);
    else passed++;
    fork
      sensor_frame(d, 40, h0, h1, glitchy);
      wait_strobe(16000, v, e, ba, bb);
    join
    wait_us(5);
    checks++;
    if ({v, e} !== {exp_v, ~exp_v}) $display("FAIL %s_strobe: valid,err=%b%b required %b%b", name, v, e, exp_v, ~exp_v);
    else passed++;
    checks++;
    if ({valid_cnt - vc0, err_cnt - ec0} !== {32'(exp_v), 32'(!exp_v)})
      $display("FAIL %s_strobe_count: valid=%0d err=%0d", name, valid_cnt - vc0, err_cnt - ec0);
    else passed++;
    checks++;
    if ({hum_int, hum_dec, temp_int, temp_dec} !== exp_data)
      $display("FAIL %s_data: got %h required %h", name, {hum_int, hum_dec, temp_int, temp_dec}, exp_data);
    else passed++;
    checks++;
    if ({ba, bb} !== 2'b10) $display("FAIL %s_busy_window: at/after strobe=%b%b required 10", name, ba, bb);
    else passed++;
    if (!exp_v) begin
      checks++;
      if (err_code !== exp_code) $display("FAIL %s_err_code: got %0d required %0d", name, err_code, exp_code);
      else passed++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dht_oe, busy, valid, err, err_code} !== 6'b0)
      $display("FAIL reset_ctrl: oe,busy,valid,err,code=%b required 000000", {dht_oe, busy, valid, err, err_code});
    else passed++;
    checks++;
    if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h0)
      $display("FAIL reset_data: got %h required 00000000", {hum_int, hum_dec, temp_int, temp_dec});
    else passed++;
  endtask

  task automatic test_good_frame;
    run_frame("good", 40'h37_00_18_05_54, 27, 70, 0, 1, 32'h37001805, 2'd0);
  endtask

  task automatic test_bad_checksum;
    run_frame("cksum", 40'h37_00_18_05_55, 27, 70, 0, 0, 32'h37001805, 2'd3);
  endtask

  task automatic test_no_response;
    int hi = 0;
    int to = 0;
    bit v = 0;
    pulse_start;
    hi = 1;
    while (dht_oe && hi < 4 * START_US * US) begin @(negedge clk); hi++; end
    checks++;
    if (hi < START_US * US - 2 || hi > START_US * US + 2)
      $display("FAIL noresp_start_low: dht_oe high %0d cycles required %0d +/-2", hi, START_US * US);
    else passed++;
    while (!err && to < 4 * TO_US * US) begin
      @(negedge clk); to++;
      if (valid) v = 1;
    end
    checks++;
    if (to < TO_US * US - 4 || to > TO_US * US + 4 || v)
      $display("FAIL noresp_timeout: err after %0d cycles valid=%b required %0d +/-4, 0", to, v, TO_US * US);
    else passed++;
    checks++;
    if (err_code !== 2'd1) $display("FAIL noresp_code: got %0d required 1", err_code);
    else passed++;
    wait_us(5);
  endtask

  task automatic test_bit_stall;
    bit v, e, ba, bb;
    pulse_start;
    fork
      sensor_frame(40'h37_00_18_05_54, 12, 27, 70, 0);
      wait_strobe(16000, v, e, ba, bb);
    join
    checks++;
    if ({v, e, err_code} !== 4'b0110) $display("FAIL stall_err: valid,err,code=%b%b%0d required 0,1,2", v, e, err_code);
    else passed++;
    checks++;
    if ({ba, bb} !== 2'b10) $display("FAIL stall_busy: at/after=%b%b required 10", ba, bb);
    else passed++;
    checks++;
    if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h37001805)
      $display("FAIL stall_data: got %h required 37001805", {hum_int, hum_dec, temp_int, temp_dec});
    else passed++;
  endtask

  task automatic test_busy_and_reset;
    int ec0;
    pulse_start;
    ec0 = err_cnt;
    fork
      sensor_frame(40'h37_00_18_05_54, 20, 27, 70, 0);
      begin
        repeat (3) begin
          repeat (60) @(negedge clk);
          pulse_start;
        end
        wait_us(START_US + 200);
        pulse_start;
      end
    join
    wait_us(20);
    checks++;
    if ({busy, dht_oe, err_cnt - ec0} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL busy_ignore_start: busy=%b oe=%b errs=%0d required 1,0,0", busy, dht_oe, err_cnt - ec0);
    else passed++;
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    checks++;
    if ({dht_oe, busy, valid, err} !== 4'b0)
      $display("FAIL midreset_ctrl: oe,busy,valid,err=%b required 0000", {dht_oe, busy, valid, err});
    else passed++;
    checks++;
    if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h0)
      $display("FAIL midreset_data: got %h required 00000000", {hum_int, hum_dec, temp_int, temp_dec});
    else passed++;
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, dht_oe} !== 2'b00) $display("FAIL rst_beats_start: busy,oe=%b required 00", {busy, dht_oe});
    else passed++;
    run_frame("after_rst", 40'h37_00_18_05_54, 27, 70, 0, 1, 32'h37001805, 2'd0);
  endtask

  task automatic test_threshold;
    run_frame("thresh", 40'h2A_01_1B_09_4F, 49, 50, 0, 1, 32'h2A011B09, 2'd0);
  endtask

  task automatic test_glitch;
`ifdef DHT_GLITCH_FILTER_EN
    run_frame("glitch", 40'h37_00_18_05_54, 27, 70, 1, 1, 32'h37001805, 2'd0);
`endif
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_no_response;
    test_bit_stall;
    test_busy_and_reset;
    test_threshold;
    test_glitch;
    checks++;
    if (both_cnt !== 0) $display("FAIL valid_err_exclusive: %0d cycles with both high", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
